// File: rtl/stopwatch_pkg.sv
// stopwatch_pkg
//   Shared definitions for the lap stopwatch: FSM state encoding, the
//   seconds rollover value and a helper that clamps a preloaded seconds
//   value into the legal 0..59 range.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUNNING = 2'd1,
    ST_PAUSED  = 2'd2,
    ST_EXPIRED = 2'd3
  } sw_state_t;

  localparam logic [5:0] SEC_MAX = 6'd59;

  // Preload values above 59 saturate instead of producing an illegal time.
  function automatic logic [5:0] clamp_sec(input logic [5:0] s);
    return (s > SEC_MAX) ? SEC_MAX : s;
  endfunction

endpackage

// File: rtl/sw_tick_gen.sv
// sw_tick_gen
//   Prescaler that turns CLK_DIV clock cycles into one single-cycle tick.
//   Ports:
//     clk   - rising-edge clock
//     reset - asynchronous active-low reset
//     run   - count enable; tick only fires while run is high
//     clr   - synchronous clear of the prescaler (has priority over run)
//     tick  - high for the cycle in which the prescaler reaches CLK_DIV-1
//   With run and clr both low the prescaler holds its phase, so a paused
//   stopwatch resumes mid-second rather than restarting the second.
module sw_tick_gen #(
  parameter int CLK_DIV = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  input  logic clr,
  output logic tick
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    tick  = 1'b0;
    if (clr) begin
      cnt_d = '0;
    end else if (run) begin
      if (cnt_q == LAST) begin
        cnt_d = '0;
        tick  = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/lap_stopwatch.sv
// lap_stopwatch
//   Up/down minute:second stopwatch with a lap-capture FIFO.
//   Ports:
//     clk, reset            - rising-edge clock, async active-low reset
//     start, stop           - run control (stop wins when both are high)
//     lap, lap_pop          - capture current time / drop FIFO head
//     load                  - preload count from load_min/load_sec (IDLE/EXPIRED)
//     mode_down             - direction, latched on a start accepted in IDLE
//     minute, seconds       - current count
//     state, expired        - FSM state (IDLE/RUNNING/PAUSED/EXPIRED)
//     lap_valid/min/sec     - FIFO head, first-word-fall-through, zero when empty
//     lap_count             - FIFO occupancy
//     lap_overflow          - sticky: a lap was dropped because the FIFO was full
module lap_stopwatch
  import stopwatch_pkg::*;
#(
  parameter int CLK_DIV   = 1,
  parameter int MIN_W     = 8,
  parameter int LAP_DEPTH = 4
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             start,
  input  logic                             stop,
  input  logic                             lap,
  input  logic                             lap_pop,
  input  logic                             load,
  input  logic                             mode_down,
  input  logic [MIN_W-1:0]                 load_min,
  input  logic [5:0]                       load_sec,
  output logic [MIN_W-1:0]                 minute,
  output logic [5:0]                       seconds,
  output logic [1:0]                       state,
  output logic                             expired,
  output logic                             lap_valid,
  output logic [MIN_W-1:0]                 lap_min,
  output logic [5:0]                       lap_sec,
  output logic [$clog2(LAP_DEPTH+1)-1:0]   lap_count,
  output logic                             lap_overflow
);

  localparam int PW    = $clog2(LAP_DEPTH);
  localparam int CNT_W = $clog2(LAP_DEPTH + 1);

  sw_state_t        state_q, state_d;
  logic [MIN_W-1:0] min_q, min_d;
  logic [5:0]       sec_q, sec_d;
  logic             dir_q, dir_d;
  logic             expired_q, expired_d;
  logic             ovf_q, ovf_d;
  logic [PW:0]      wr_ptr_q, wr_ptr_d;
  logic [PW:0]      rd_ptr_q, rd_ptr_d;
  logic [MIN_W-1:0] mem_min_q [LAP_DEPTH];
  logic [MIN_W-1:0] mem_min_d [LAP_DEPTH];
  logic [5:0]       mem_sec_q [LAP_DEPTH];
  logic [5:0]       mem_sec_d [LAP_DEPTH];

  logic tick;
  logic run;
  logic clr;
  logic fifo_empty;
  logic fifo_full;
  logic push_req;
  logic do_pop;
  logic do_push;
  logic do_load;

  assign run = (state_q == ST_RUNNING);
  assign clr = (state_q == ST_IDLE) || (state_q == ST_EXPIRED);

  sw_tick_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_tick_gen (
    .clk   (clk),
    .reset (reset),
    .run   (run),
    .clr   (clr),
    .tick  (tick)
  );

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                      (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
  assign push_req   = lap && ((state_q == ST_RUNNING) || (state_q == ST_PAUSED));
  assign do_pop     = lap_pop && !fifo_empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
  assign do_push    = push_req && (!fifo_full || do_pop);

  always_comb begin
    state_d   = state_q;
    min_d     = min_q;
    sec_d     = sec_q;
    dir_d     = dir_q;
    do_load   = 1'b0;
    ovf_d     = ovf_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    mem_min_d = mem_min_q;
    mem_sec_d = mem_sec_q;

    case (state_q)
      ST_IDLE: begin
        if (!stop) begin
          if (load) begin
            do_load = 1'b1;
          end else if (start) begin
            dir_d = mode_down;
            // A countdown from 0:00 has nothing to count.
            if (mode_down && (min_q == '0) && (sec_q == '0)) begin
              state_d = ST_EXPIRED;
            end else begin
              state_d = ST_RUNNING;
            end
          end
        end
      end

      ST_RUNNING: begin
        if (tick) begin
          if (dir_q) begin
            if (sec_q != '0) begin
              sec_d = sec_q - 1'b1;
            end else if (min_q != '0) begin
              sec_d = SEC_MAX;
              min_d = min_q - 1'b1;
            end
            if ((min_q == '0) && (sec_q <= 6'd1)) begin
              state_d = ST_EXPIRED;
            end
          end else begin
            if (sec_q == SEC_MAX) begin
              sec_d = '0;
              min_d = min_q + 1'b1;
            end else begin
              sec_d = sec_q + 1'b1;
            end
          end
        end
        // Reaching zero on the stop cycle still expires: the countdown is done.
        if (stop && (state_d != ST_EXPIRED)) begin
          state_d = ST_PAUSED;
        end
      end

      ST_PAUSED: begin
        if (!stop && start) begin
          state_d = ST_RUNNING;
        end
      end

      ST_EXPIRED: begin
        if (load) begin
          do_load = 1'b1;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    if (do_push) begin
      mem_min_d[wr_ptr_q[PW-1:0]] = min_q;
      mem_sec_d[wr_ptr_q[PW-1:0]] = sec_q;
      wr_ptr_d = wr_ptr_q + 1'b1;
    end else if (push_req) begin
      ovf_d = 1'b1;
    end

    if (do_load) begin
      state_d  = ST_IDLE;
      min_d    = load_min;
      sec_d    = clamp_sec(load_sec);
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      ovf_d    = 1'b0;
    end

    expired_d = (state_d == ST_EXPIRED);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      min_q     <= '0;
      sec_q     <= '0;
      dir_q     <= 1'b0;
      expired_q <= 1'b0;
      ovf_q     <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      for (int i = 0; i < LAP_DEPTH; i++) begin
        mem_min_q[i] <= '0;
        mem_sec_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      min_q     <= min_d;
      sec_q     <= sec_d;
      dir_q     <= dir_d;
      expired_q <= expired_d;
      ovf_q     <= ovf_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      mem_min_q <= mem_min_d;
      mem_sec_q <= mem_sec_d;
    end
  end

  assign minute       = min_q;
  assign seconds      = sec_q;
  assign state        = state_q;
  assign expired      = expired_q;
  assign lap_valid    = !fifo_empty;
  assign lap_min      = fifo_empty ? '0 : mem_min_q[rd_ptr_q[PW-1:0]];
  assign lap_sec      = fifo_empty ? '0 : mem_sec_q[rd_ptr_q[PW-1:0]];
  assign lap_count    = CNT_W'(wr_ptr_q - rd_ptr_q);
  assign lap_overflow = ovf_q;

endmodule

// File: tb/tb_lap_stopwatch.sv
// tb_lap_stopwatch
//   Drives two stopwatches (CLK_DIV=1 and CLK_DIV=4) with the same directed
//   command sequence. Each has a reference model that tracks time as a plain
//   count of elapsed seconds and the lap FIFO as an ordered list; every
//   falling edge both DUTs are compared against their model. Literal
//   expectations at key points pin the model itself.
module tb_lap_stopwatch;

  localparam int LAP_DEPTH = 4;
  localparam int TOTAL_MAX = 256 * 60;

  logic       clk = 1'b0;
  logic       reset;
  logic       start, stop, lap, lap_pop, load, mode_down;
  logic [7:0] load_min;
  logic [5:0] load_sec;

  logic [7:0] d1_minute, d4_minute, d1_lap_min, d4_lap_min;
  logic [5:0] d1_seconds, d4_seconds, d1_lap_sec, d4_lap_sec;
  logic [1:0] d1_state, d4_state;
  logic       d1_expired, d4_expired, d1_lap_valid, d4_lap_valid;
  logic [2:0] d1_lap_count, d4_lap_count;
  logic       d1_lap_overflow, d4_lap_overflow;

  int  checks = 0;
  int  errors = 0;
  bit  check_en = 1'b0;

  // Model: index 0 follows the CLK_DIV=1 DUT, index 1 the CLK_DIV=4 DUT.
  // m_st uses 0 idle, 1 running, 2 paused, 3 expired; m_total is seconds.
  int m_st    [2];
  int m_total [2];
  int m_phase [2];
  int m_dir   [2];
  int m_ovf   [2];
  int m_n     [2];
  int m_fifo  [2][LAP_DEPTH];

  always #5 clk = ~clk;

  lap_stopwatch #(.CLK_DIV(1), .MIN_W(8), .LAP_DEPTH(LAP_DEPTH)) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .lap(lap),
    .lap_pop(lap_pop), .load(load), .mode_down(mode_down),
    .load_min(load_min), .load_sec(load_sec),
    .minute(d1_minute), .seconds(d1_seconds), .state(d1_state),
    .expired(d1_expired), .lap_valid(d1_lap_valid), .lap_min(d1_lap_min),
    .lap_sec(d1_lap_sec), .lap_count(d1_lap_count), .lap_overflow(d1_lap_overflow)
  );

  lap_stopwatch #(.CLK_DIV(4), .MIN_W(8), .LAP_DEPTH(LAP_DEPTH)) dut4 (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .lap(lap),
    .lap_pop(lap_pop), .load(load), .mode_down(mode_down),
    .load_min(load_min), .load_sec(load_sec),
    .minute(d4_minute), .seconds(d4_seconds), .state(d4_state),
    .expired(d4_expired), .lap_valid(d4_lap_valid), .lap_min(d4_lap_min),
    .lap_sec(d4_lap_sec), .lap_count(d4_lap_count), .lap_overflow(d4_lap_overflow)
  );

  task automatic resetModel(input int k);
    m_st[k] = 0; m_total[k] = 0; m_phase[k] = 0; m_dir[k] = 0;
    m_ovf[k] = 0; m_n[k] = 0;
    for (int i = 0; i < LAP_DEPTH; i++) m_fifo[k][i] = 0;
  endtask

  // One clock edge of stopwatch behaviour for model k.
  task automatic stepModel(input int k, input int div);
    int  nst, ntotal, lsec;
    bit  tick, can_pop, push, do_load;
    nst     = m_st[k];
    ntotal  = m_total[k];
    do_load = 1'b0;
    tick    = (m_st[k] == 1) && (m_phase[k] == div - 1);
    can_pop = lap_pop && (m_n[k] > 0);
    push    = lap && (m_st[k] == 1 || m_st[k] == 2);

    if (can_pop) begin
      for (int i = 0; i < LAP_DEPTH - 1; i++) m_fifo[k][i] = m_fifo[k][i+1];
      m_n[k]--;
    end
    if (push) begin
      if (m_n[k] == LAP_DEPTH) m_ovf[k] = 1;
      else begin
        m_fifo[k][m_n[k]] = m_total[k];
        m_n[k]++;
      end
    end

    case (m_st[k])
      0: if (!stop) begin
           if (load) do_load = 1'b1;
           else if (start) begin
             m_dir[k] = int'(mode_down);
             nst = (mode_down && ntotal == 0) ? 3 : 1;
           end
         end
      1: begin
           if (tick) begin
             if (m_dir[k] != 0) begin
               if (ntotal > 0) ntotal--;
               if (ntotal == 0) nst = 3;
             end else begin
               ntotal = (ntotal + 1) % TOTAL_MAX;
             end
           end
           if (stop && nst == 1) nst = 2;
         end
      2: if (!stop && start) nst = 1;
      default: if (load) do_load = 1'b1;
    endcase

    if (do_load) begin
      lsec   = (int'(load_sec) > 59) ? 59 : int'(load_sec);
      ntotal = int'(load_min) * 60 + lsec;
      nst    = 0;
      m_n[k] = 0;
      m_ovf[k] = 0;
    end

    if (m_st[k] == 0 || m_st[k] == 3) m_phase[k] = 0;
    else if (m_st[k] == 1) m_phase[k] = (m_phase[k] + 1) % div;

    m_st[k]    = nst;
    m_total[k] = ntotal;
  endtask

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      resetModel(0);
      resetModel(1);
    end else begin
      stepModel(0, 1);
      stepModel(1, 4);
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic compareModel(input string tag, input int k,
                              input logic [1:0] st, input logic [7:0] mn,
                              input logic [5:0] sc, input logic ex,
                              input logic lv, input logic [7:0] lm,
                              input logic [5:0] ls, input logic [2:0] lc,
                              input logic lo);
    int head;
    head = (m_n[k] > 0) ? m_fifo[k][0] : 0;
    checkOutput({tag, ".state"},        32'(st), m_st[k]);
    checkOutput({tag, ".minute"},       32'(mn), m_total[k] / 60);
    checkOutput({tag, ".seconds"},      32'(sc), m_total[k] % 60);
    checkOutput({tag, ".expired"},      32'(ex), (m_st[k] == 3) ? 1 : 0);
    checkOutput({tag, ".lap_valid"},    32'(lv), (m_n[k] > 0) ? 1 : 0);
    checkOutput({tag, ".lap_min"},      32'(lm), head / 60);
    checkOutput({tag, ".lap_sec"},      32'(ls), head % 60);
    checkOutput({tag, ".lap_count"},    32'(lc), m_n[k]);
    checkOutput({tag, ".lap_overflow"}, 32'(lo), m_ovf[k]);
  endtask

  // Called on a falling edge: commands are sampled on the next rising edge,
  // dropped on the following falling edge, then idle cycles elapse.
  task automatic applyStimulus(input bit st, input bit sp, input bit lp,
                               input bit pp, input bit ld, input int idle);
    start = st; stop = sp; lap = lp; lap_pop = pp; load = ld;
    @(negedge clk);
    start = 1'b0; stop = 1'b0; lap = 1'b0; lap_pop = 1'b0; load = 1'b0;
    repeat (idle) @(negedge clk);
  endtask

  task automatic doReset();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0;
    start = 1'b0; stop = 1'b0; lap = 1'b0; lap_pop = 1'b0; load = 1'b0;
    mode_down = 1'b0; load_min = 8'd0; load_sec = 6'd0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    check_en = 1'b1;

    fork
      forever begin
        @(negedge clk);
        if (check_en) begin
          compareModel("div1", 0, d1_state, d1_minute, d1_seconds, d1_expired,
                       d1_lap_valid, d1_lap_min, d1_lap_sec, d1_lap_count, d1_lap_overflow);
          compareModel("div4", 1, d4_state, d4_minute, d4_seconds, d4_expired,
                       d4_lap_valid, d4_lap_min, d4_lap_sec, d4_lap_count, d4_lap_overflow);
        end
      end
    join_none

    // Reset values
    checkOutput("rst_state", 32'(d1_state), 0);
    checkOutput("rst_seconds", 32'(d1_seconds), 0);
    checkOutput("rst_lap_count", 32'(d1_lap_count), 0);

    // 65 running edges (the stop edge included) then pause: 1:05
    applyStimulus(1, 0, 0, 0, 0, 64);
    applyStimulus(0, 1, 0, 0, 0, 0);
    checkOutput("pause_state", 32'(d1_state), 2);
    checkOutput("pause_minute", 32'(d1_minute), 1);
    checkOutput("pause_seconds", 32'(d1_seconds), 5);
    applyStimulus(1, 0, 0, 0, 0, 10);
    checkOutput("resume_minute", 32'(d1_minute), 1);
    checkOutput("resume_seconds", 32'(d1_seconds), 15);
    checkOutput("resume_state", 32'(d1_state), 1);

    // start+stop together: ignored in IDLE, pauses in RUNNING; push+pop on full
    doReset();
    applyStimulus(1, 1, 0, 0, 0, 0);
    checkOutput("startstop_idle", 32'(d1_state), 0);
    applyStimulus(1, 0, 0, 0, 0, 2);
    for (int i = 0; i < 4; i++) applyStimulus(0, 0, 1, 0, 0, 1);
    checkOutput("full_count", 32'(d1_lap_count), 4);
    checkOutput("full_head", 32'(d1_lap_sec), 2);
    applyStimulus(0, 0, 1, 1, 0, 0);
    checkOutput("pushpop_count", 32'(d1_lap_count), 4);
    checkOutput("pushpop_ovf", 32'(d1_lap_overflow), 0);
    checkOutput("pushpop_head", 32'(d1_lap_sec), 4);
    applyStimulus(1, 1, 0, 0, 0, 0);
    checkOutput("startstop_run", 32'(d1_state), 2);

    // Five laps at 2,4,6,8,10: last one overflows; pops return 2,4,6,8
    doReset();
    applyStimulus(1, 0, 0, 0, 0, 2);
    for (int i = 0; i < 5; i++) applyStimulus(0, 0, 1, 0, 0, 1);
    applyStimulus(0, 1, 0, 0, 0, 0);
    checkOutput("ovf_count", 32'(d1_lap_count), 4);
    checkOutput("ovf_flag", 32'(d1_lap_overflow), 1);
    checkOutput("pop_head0", 32'(d1_lap_sec), 2);
    applyStimulus(0, 0, 0, 1, 0, 0);
    checkOutput("pop_head1", 32'(d1_lap_sec), 4);
    applyStimulus(0, 0, 0, 1, 0, 0);
    checkOutput("pop_head2", 32'(d1_lap_sec), 6);
    applyStimulus(0, 0, 0, 1, 0, 0);
    checkOutput("pop_head3", 32'(d1_lap_sec), 8);
    applyStimulus(0, 0, 0, 1, 0, 0);
    checkOutput("pop_empty_valid", 32'(d1_lap_valid), 0);
    checkOutput("pop_empty_sec", 32'(d1_lap_sec), 0);
    applyStimulus(0, 0, 0, 1, 0, 0);
    checkOutput("pop_on_empty", 32'(d1_lap_count), 0);

    // Countdown from 0:03 expires after three ticks; start then ignored
    doReset();
    mode_down = 1'b1; load_min = 8'd0; load_sec = 6'd3;
    applyStimulus(0, 0, 0, 0, 1, 0);
    checkOutput("load_seconds", 32'(d1_seconds), 3);
    applyStimulus(1, 0, 0, 0, 0, 3);
    checkOutput("down_seconds", 32'(d1_seconds), 0);
    checkOutput("down_state", 32'(d1_state), 3);
    checkOutput("down_expired", 32'(d1_expired), 1);
    applyStimulus(1, 0, 0, 0, 0, 1);
    checkOutput("expired_hold", 32'(d1_state), 3);
    load_sec = 6'd0;
    applyStimulus(0, 0, 0, 0, 1, 0);
    checkOutput("reload_idle", 32'(d1_state), 0);
    applyStimulus(1, 0, 0, 0, 0, 0);
    checkOutput("zero_start_expired", 32'(d1_state), 3);

    // Preload clamp and up-count wrap at 255:59
    mode_down = 1'b0; load_min = 8'd5; load_sec = 6'd63;
    applyStimulus(0, 0, 0, 0, 1, 0);
    checkOutput("clamp_minute", 32'(d1_minute), 5);
    checkOutput("clamp_seconds", 32'(d1_seconds), 59);
    load_min = 8'd255; load_sec = 6'd58;
    applyStimulus(0, 0, 0, 0, 1, 0);
    applyStimulus(1, 0, 0, 0, 0, 2);
    checkOutput("wrap_minute", 32'(d1_minute), 0);
    checkOutput("wrap_seconds", 32'(d1_seconds), 0);
    checkOutput("wrap_state", 32'(d1_state), 1);

    // Down-count borrow from 2:00
    doReset();
    mode_down = 1'b1; load_min = 8'd2; load_sec = 6'd0;
    applyStimulus(0, 0, 0, 0, 1, 0);
    applyStimulus(1, 0, 0, 0, 0, 1);
    checkOutput("borrow_minute", 32'(d1_minute), 1);
    checkOutput("borrow_seconds", 32'(d1_seconds), 59);

    // Prescaler phase survives a pause: 10 run, 6 paused, 6 run edges
    doReset();
    mode_down = 1'b0;
    applyStimulus(1, 0, 0, 0, 0, 9);
    applyStimulus(0, 1, 0, 0, 0, 5);
    applyStimulus(1, 0, 0, 0, 0, 6);
    checkOutput("div4_seconds", 32'(d4_seconds), 4);
    checkOutput("div1_seconds", 32'(d1_seconds), 16);

    // Asynchronous reset between clock edges
    doReset();
    applyStimulus(1, 0, 0, 0, 0, 5);
    applyStimulus(0, 0, 1, 0, 0, 3);
    #2;
    reset = 1'b0;
    #1;
    checkOutput("async_state", 32'(d1_state), 0);
    checkOutput("async_seconds", 32'(d1_seconds), 0);
    checkOutput("async_lap_count", 32'(d1_lap_count), 0);
    checkOutput("async_lap_valid", 32'(d1_lap_valid), 0);
    checkOutput("async_div4_seconds", 32'(d4_seconds), 0);
    @(negedge clk);
    reset = 1'b1;
    applyStimulus(1, 0, 0, 0, 0, 0);
    checkOutput("post_reset_start", 32'(d1_state), 1);
    checkOutput("post_reset_seconds", 32'(d1_seconds), 0);

    repeat (3) @(negedge clk);
    check_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/lap_stopwatch.md
LAP_STOPWATCH -- requirements
Module: lap_stopwatch

Interface
REQ-001 SHALL have parameter CLK_DIV, default 1, meaning clk cycles per one-second tick (>=1).
REQ-002 SHALL have parameter MIN_W, default 8, meaning width of the minute counter.
REQ-003 SHALL have parameter LAP_DEPTH, default 4, meaning lap FIFO entries (power of 2, >=2).
REQ-004 SHALL have clk  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have reset  input  1  asynchronous, active-low reset.
REQ-006 SHALL have start, stop, lap, lap_pop, load  input  1 each  synchronous single-cycle commands.
REQ-007 SHALL have mode_down  input  1  count direction: 0 up, 1 down; sampled only on a start accepted in IDLE.
REQ-008 SHALL have load_min  input  MIN_W  and load_sec  input  6  preload value.
REQ-009 SHALL have minute  output  MIN_W  and seconds  output  6  current count.
REQ-010 SHALL have state  output  2  FSM state: IDLE=0, RUNNING=1, PAUSED=2, EXPIRED=3.
REQ-011 SHALL have expired  output  1, high whenever state==EXPIRED.
REQ-012 SHALL have lap_valid  output  1, lap_min  output  MIN_W, lap_sec  output  6  FIFO head, first-word-fall-through.
REQ-013 SHALL have lap_count  output  clog2(LAP_DEPTH+1), lap_overflow  output  1 sticky.

Function
REQ-014 SHALL transition: IDLE-start->RUNNING; RUNNING-stop->PAUSED; PAUSED-start->RUNNING; IDLE/EXPIRED-load->IDLE; RUNNING-down count reaches 0:00->EXPIRED.
REQ-015 SHALL update state on the clk edge where the command is sampled; new state visible the following cycle.
REQ-016 SHALL give stop priority over start when both are high; start in RUNNING, stop in IDLE/PAUSED/EXPIRED, load in RUNNING/PAUSED are ignored.
REQ-017 SHALL generate a tick when the prescaler reaches CLK_DIV-1 in RUNNING; prescaler holds in PAUSED, clears to 0 in IDLE/EXPIRED.
REQ-018 SHALL, with CLK_DIV=1, advance the count on every clk edge while state==RUNNING.
REQ-019 SHALL in up mode increment seconds 0..59, on 59 wrap to 0 and increment minute; at {2^MIN_W-1, 59} wrap to {0,0} and stay RUNNING.
REQ-020 SHALL in down mode decrement seconds; on 0 with minute>0 set seconds 59 and decrement minute; on the tick producing {0,0} enter EXPIRED.
REQ-021 SHALL on start in IDLE with mode_down=1 and count {0,0} go directly to EXPIRED.
REQ-022 SHALL on accepted load set minute=load_min, seconds=min(load_sec,59), clear lap FIFO and lap_overflow.
REQ-023 SHALL push the pre-update {minute,seconds} into the lap FIFO on lap in RUNNING or PAUSED; lap ignored in IDLE/EXPIRED.
REQ-024 SHALL drop a push when full and no pop that cycle, and set lap_overflow until reset or load.
REQ-025 SHALL pop the head on lap_pop when lap_valid; lap_pop on empty ignored.
REQ-026 SHALL accept simultaneous push and pop in any occupancy, lap_count unchanged when non-empty, and when empty the pushed entry becomes head next cycle.
REQ-027 SHALL hold lap_min/lap_sec at 0 while lap_valid=0.

Reset
REQ-028 SHALL, on reset low, asynchronously force state=IDLE, minute=0, seconds=0, prescaler=0, direction=up, FIFO empty, lap_count=0, lap_valid=0, lap_overflow=0, expired=0.
REQ-029 SHALL, on reset mid-operation, abandon count and FIFO contents; first command after release is sampled on the first rising edge with reset high.

Structure
REQ-030 SHALL place state encoding, SEC_MAX=59 and state typedef in shared package stopwatch_pkg.
REQ-031 SHALL implement the prescaler as sub-module sw_tick_gen (ports clk, reset, run, clr, tick; parameter CLK_DIV).
REQ-032 SHALL implement the lap FIFO inline as a LAP_DEPTH register array with read/write pointers one bit wider than clog2(LAP_DEPTH).

Verification (CLK_DIV=1, MIN_W=8, LAP_DEPTH=4 unless noted)
REQ-033 SHALL cover: reset, start pulse, 65 cycles, stop -> state=PAUSED, minute=1, seconds=5; start, 10 cycles -> minute=1, seconds=15.
REQ-034 SHALL cover: load {0,3}, mode_down=1, start -> 3 cycles later {0,0}, state=EXPIRED, expired=1; further start ignored.
REQ-035 SHALL cover: 5 laps in RUNNING at counts 2,4,6,8,10 -> lap_count=4, lap_overflow=1, pops return 2,4,6,8 in order, then lap_valid=0.
REQ-036 SHALL cover: start and stop high together in IDLE then RUNNING -> stay IDLE, then PAUSED; lap+lap_pop same cycle on full FIFO -> lap_count stays 4, no overflow.
REQ-037 SHALL cover: CLK_DIV=4, RUNNING 10 cycles, stop 6 cycles, start 6 cycles -> seconds=4 (prescaler held across pause).
REQ-038 SHALL cover: reset asserted mid-RUNNING between clk edges -> outputs zero immediately without a clk edge.
